// File: rtl/adder4b_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adder4b_seq_ctrl_pkg
// Shared definitions for the nibble-serial add/subtract sequencer:
//   - state_t   : controller state encoding (IDLE/RUN/DONE; 2'd3 is illegal)
//   - clog2_min1: ceiling log2 clamped to at least 1, used to size the
//                 nibble index counter
// -----------------------------------------------------------------------------
package adder4b_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never smaller than 1 so a single-nibble build still gets
    // a legal one-bit counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/adder4b.sv
// -----------------------------------------------------------------------------
// adder4b
// Purely combinational 4-bit ripple-carry adder slice.
// Ports:
//   s    out 4  sum nibble
//   c4   out 1  carry out of bit 3
//   a    in  4  operand A nibble
//   b    in  4  operand B nibble
//   c_in in  1  carry in to bit 0
// -----------------------------------------------------------------------------
module adder4b (
    output logic [3:0] s,
    output logic       c4,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);

    logic [4:0] cy;

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no
        // latch can be inferred.
        cy    = '0;
        s     = '0;
        cy[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]      = a[i] ^ b[i] ^ cy[i];
            cy[i + 1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
        c4 = cy[4];
    end

endmodule

// File: rtl/adder4b_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder4b_seq_ctrl
// Computes a WIDTH-bit add or subtract by time-sharing one adder4b slice,
// one nibble per clock, LSB nibble first, with the carry registered between
// nibbles. Valid/ready handshake on request and result sides.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operation request
//   in_ready   out 1      controller can accept a request (IDLE)
//   a, b       in  WIDTH  operands
//   c_in       in  1      carry-in (add mode only)
//   sub        in  1      0: a+b+c_in, 1: a-b
//   out_valid  out 1      result available (DONE)
//   out_ready  in  1      consumer accepts result
//   sum        out WIDTH  result, modulo 2^WIDTH
//   c_out      out 1      carry out of the MSB nibble (sub: 1 = no borrow)
//   ovf        out 1      two's-complement overflow
//   busy       out 1      high in RUN or DONE
// -----------------------------------------------------------------------------
module adder4b_seq_ctrl
    import adder4b_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = clog2_min1(NIB);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         s_nib;
    logic               c4;
    logic               last_nib;

    // Current nibble of the held operands; idx*4 is formed by concatenation.
    assign a_nib    = a_reg[{idx, 2'b00} +: 4];
    assign b_nib    = b_reg[{idx, 2'b00} +: 4];
    assign last_nib = (idx == IDX_W'(NIB - 1));

    adder4b u_adder (
        .s    (s_nib),
        .c4   (c4),
        .a    (a_nib),
        .b    (b_nib),
        .c_in (carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = last_nib ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath: operand capture, nibble accumulation and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert B and force carry-in.
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= s_nib;
                    carry                  <= c4;
                    if (last_nib) begin
                        c_out <= c4;
                        // b_reg already holds the inverted operand in sub mode,
                        // so one overflow rule covers both operations.
                        ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (s_nib[3] != a_reg[WIDTH-1]);
                        idx   <= '0;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder4b_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder4b_seq_ctrl
// Directed self-checking bench for adder4b_seq_ctrl (WIDTH = 16). Expected
// results come from a behavioural arithmetic model and flow through a
// scoreboard queue: pushed when a request is driven, popped when out_valid
// is observed.
// -----------------------------------------------------------------------------
module tb_adder4b_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t last_exp;

    adder4b_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t           r;
        logic [WIDTH-1:0] yy;
        logic           cc;
        logic [WIDTH:0] f;
        yy      = s ? ~y : y;
        cc      = s ? 1'b1 : ci;
        f       = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(cc);
        r.sum   = f[WIDTH-1:0];
        r.c_out = f[WIDTH];
        r.ovf   = (x[WIDTH-1] == yy[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // accept edge with in_valid dropped.
    task automatic send_op(input string tag, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, input logic ci, input logic s);
        sb.push_back(model(x, y, ci, s));
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = s;
        in_valid = 1'b1;
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, then compares against the scoreboard.
    // lat counts cycles after the accept edge; lowcnt counts cycles with
    // in_ready low up to and including the first out_valid cycle.
    task automatic wait_result(input string tag, output int lat, output int lowcnt);
        exp_t e;
        bit   got;
        int   n;
        got    = 1'b0;
        lat    = 0;
        lowcnt = 0;
        n      = 1;
        forever begin
            if (in_ready !== 1'b1) lowcnt++;
            if (out_valid === 1'b1) begin
                got = 1'b1;
                lat = n;
                break;
            end
            if (n >= 40) break;
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid seen"}, 32'(got), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (got) begin
                last_exp = e;
                check({tag, " sum"},   32'(sum),   32'(e.sum));
                check({tag, " c_out"}, 32'(c_out), 32'(e.c_out));
                check({tag, " ovf"},   32'(ovf),   32'(e.ovf));
            end
        end
    endtask

    initial begin
        int  lat;
        int  lowcnt;
        bit  saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset sum",       32'(sum),       32'd0);
        check("reset c_out",     32'(c_out),     32'd0);
        check("reset ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero add: latency and in_ready-low window.
        send_op("t1", 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("t1 busy in RUN", 32'(busy), 32'd1);
        wait_result("t1", lat, lowcnt);
        check("t1 latency", 32'(lat), 32'(NIB + 1));
        check("t1 in_ready low cycles", 32'(lowcnt), 32'(NIB + 1));
        check("t1 busy in DONE", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1 in_ready after done", 32'(in_ready), 32'd1);
        check("t1 out_valid after done", 32'(out_valid), 32'd0);

        // Carry ripple across all nibbles.
        send_op("t2a", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_result("t2a", lat, lowcnt);
        @(negedge clk);
        send_op("t2b", 16'h0001, 16'hFFFF, 1'b0, 1'b0);
        wait_result("t2b", lat, lowcnt);
        @(negedge clk);

        // Signed overflow, add and sub.
        send_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result("t3a", lat, lowcnt);
        @(negedge clk);
        send_op("t3b", 16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_result("t3b", lat, lowcnt);
        @(negedge clk);

        // Subtraction edges; c_in is ignored in sub mode.
        send_op("t4a", 16'h0001, 16'h0001, 1'b0, 1'b1);
        wait_result("t4a", lat, lowcnt);
        @(negedge clk);
        send_op("t4b", 16'h0000, 16'h0001, 1'b1, 1'b1);
        wait_result("t4b", lat, lowcnt);
        @(negedge clk);

        // Backpressure: hold DONE for 6 cycles while new requests are offered.
        out_ready = 1'b0;
        send_op("t5", 16'h1111, 16'h2222, 1'b1, 1'b0);
        wait_result("t5", lat, lowcnt);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            a        = 16'($urandom);
            b        = 16'($urandom);
            c_in     = 1'($urandom);
            sub      = 1'($urandom);
            @(negedge clk);
            check("t5 hold out_valid", 32'(out_valid), 32'd1);
            check("t5 hold in_ready",  32'(in_ready),  32'd0);
            check("t5 hold sum",       32'(sum),       32'(last_exp.sum));
            check("t5 hold c_out",     32'(c_out),     32'(last_exp.c_out));
            check("t5 hold ovf",       32'(ovf),       32'(last_exp.ovf));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5 idle in_ready", 32'(in_ready), 32'd1);
        check("t5 idle busy",     32'(busy),     32'd0);
        send_op("t5n", 16'hABCD, 16'h1234, 1'b0, 1'b1);
        wait_result("t5n", lat, lowcnt);
        @(negedge clk);

        // Reset on the 2nd RUN cycle aborts the operation.
        send_op("t6", 16'h1234, 16'h1111, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 in_ready after rst",  32'(in_ready),  32'd1);
        check("t6 sum after rst",       32'(sum),       32'd0);
        check("t6 busy after rst",      32'(busy),      32'd0);
        rst       = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("t6 no out_valid after abort", 32'(saw_valid), 32'd0);
        send_op("t6n", 16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_result("t6n", lat, lowcnt);
        check("t6n sum constant", 32'(sum), 32'h2345);
        @(negedge clk);

        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder4b_seq_ctrl.md
Name: adder4b_seq_ctrl

Overview:
- Multi-cycle sequencer that computes WIDTH-bit add/subtract by time-sharing one 4-bit ripple adder slice (adder4b), one nibble per clock, LSB nibble first.
- Carry is registered between nibbles.
- Valid/ready handshake on both sides.
- Sits between a requester (ALU front end or testbench driver) and the shared 4-bit adder datapath; it is the only driver of that adder.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4: number of nibble passes (derived; do not override).
- IDX_W, clog2(NIB) with a minimum of 1: width of the nibble index counter (derived).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  controller can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in (add mode only)
- sub  in  1  0 = A+B+c_in, 1 = A-B (c_in ignored)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- c_out  out  1  carry out of MSB nibble (sub: 1 = no borrow)
- ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset is synchronous and active-high on clk, and is the only reset.
- Values after reset:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - sum = 0, c_out = 0, ovf = 0.
  - Internal registers a_reg, b_reg, carry and idx = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: a_reg <= a; b_reg <= sub ? ~b : b; carry <= sub ? 1 : c_in; idx <= 0; sum <= 0; go to RUN.
  - a, b, c_in and sub are sampled only at this handshake edge.
- RUN:
  - in_ready = 0.
  - The adder is driven combinationally with a_reg[4*idx +: 4], b_reg[4*idx +: 4] and carry.
  - Each edge: sum nibble idx <= S; carry <= C4; idx <= idx + 1.
  - When idx == NIB-1: c_out <= C4, then go to DONE.
  - Also at that edge: ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (S[3] != a_reg[WIDTH-1]).
- DONE:
  - out_valid = 1; sum, c_out and ovf are held stable.
  - When out_ready is high at an edge: go to IDLE (out_valid = 0 and in_ready = 1 from the next cycle).
  - Result registers keep their last values in IDLE.
- Latency:
  - Accept at edge E0; nibbles are processed at edges E1..E_NIB; out_valid is high in the cycle after E_NIB.
  - Minimum initiation interval is NIB+2 cycles; requests never overlap.
- In-flight ordering: in_valid while in_ready = 0 is ignored; the requester must hold the request until accepted.
- idx wrap: idx never exceeds NIB-1; it is cleared on accept.
- Arithmetic:
  - All modulo 2^WIDTH; sum has no extra bit.
  - c_out is the true carry of the full WIDTH-bit add.
  - In sub mode, subtraction is a + ~b + 1.
- Reset mid-operation (RUN or DONE): the operation is aborted and no out_valid is produced; the reset values above apply at the next cycle.
- Simultaneous rst and a handshake: rst wins and the request is not accepted.
- out_ready while out_valid = 0 has no effect.

Decomposition:
- Shared include adder_ctrl_defs.vh holds:
  - State localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2; encoding 2'd3 is illegal and recovers to IDLE.
  - The clog2 function used for IDX_W.
- Exactly one sub-module instance: the existing adder4b (port order S, C4, a, b, c_in), purely combinational.
- All sequencing, operand muxing and result assembly live in adder4b_seq_ctrl.

Test Plan:
- 0x0000 + 0x0000, c_in = 0, sub = 0, out_ready = 1: sum = 0x0000, c_out = 0, ovf = 0; out_valid exactly 5 cycles after the accept edge; in_ready low for 5 cycles.
- 0xFFFF + 0x0000, c_in = 1 (carry ripples across all nibbles): sum = 0x0000, c_out = 1, ovf = 0. Then 0x0001 + 0xFFFF, c_in = 0: sum = 0x0000, c_out = 1.
- 0x7FFF + 0x0001, add: sum = 0x8000, c_out = 0, ovf = 1. Then sub 0x8000 - 0x0001: sum = 0x7FFF, c_out = 1, ovf = 1.
- Sub 0x0001 - 0x0001 with c_in = 0: sum = 0x0000, c_out = 1. Sub 0x0000 - 0x0001 with c_in = 1 (c_in ignored): sum = 0xFFFF, c_out = 0, ovf = 0.
- Backpressure: out_ready low for 6 cycles in DONE, with in_valid pulsing and new operands changing. Required:
  - out_valid, sum, c_out and ovf stay stable; in_ready = 0; the new request is not taken.
  - After out_ready = 1: IDLE, and the next request completes correctly.
- Reset asserted on the 2nd RUN cycle of 0x1234 + 0x1111:
  - out_valid is never asserted; in_ready = 1 and sum = 0 the cycle after reset.
  - A following request 0x1234 + 0x1111 yields 0x2345, c_out = 0.
